vga_scan_gen: RTL and testbench

//  Raster scan generator that drives the hpos/vpos coordinate bus consumed by
//  the brick colour logic (col/row/hpos/vpos -> couleur). It produces
//  640x480@60 VGA timing, syncs and blanking from one system clock.
//  It also registers the returned 5-bit couleur into a blanked, sync-aligned

---
 rtl/vga_scan_gen.sv | 144 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// ---------------------------------------------------------------------------
// vga_scan_gen
//   Raster scan generator for 640x480@60 VGA (timing set by parameters).
//   Walks hpos/vpos across the frame once per pixel-clock enable. It registers
//   the colour that the brick logic returns for that position into a blanked
//   pixel output. The syncs are registered on the same enable, so they stay
//   aligned with that pixel output.
//
//   Optional feature macro: VGA_TESTPATTERN_EN
//     defined   -> couleur is ignored, visible pixels show {hpos[7:5], vpos[6:5]}
//     undefined -> visible pixels show couleur
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous reset, active low
//   hpos         out  current pixel column, 0..H_TOT-1
//   vpos         out  current line, 0..V_TOT-1
//   active       out  hpos/vpos inside the visible area (combinational)
//   couleur      in   colour from brick logic, combinational from hpos/vpos
//   pix_out      out  registered colour, 0 while blanked
//   hsync_n      out  horizontal sync, active low, aligned to pix_out
//   vsync_n      out  vertical sync, active low, aligned to pix_out
//   blank        out  1 outside the visible area, aligned to pix_out
//   frame_start  out  one-clk pulse on the pix_ce that enters hpos=0,vpos=0
//   pix_ce       out  pixel clock enable, one clk wide every CLK_DIV clks
// ---------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] hpos,
    output logic [10:0] vpos,
    output logic        active,
    input  logic [4:0]  couleur,
    output logic [4:0]  pix_out,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        frame_start,
    output logic        pix_ce
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [10:0]      H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0]      H_VIS_W  = 11'(H_VIS);
    localparam logic [10:0]      V_VIS_W  = 11'(V_VIS);
    localparam logic [10:0]      HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0]      VS_START = 11'(V_VIS + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             h_last;
    logic             v_last;
    logic             hsync_on;
    logic             vsync_on;
    logic [4:0]       vis_colour;

    // ------------------------------------------------------------------
    // Pixel divider
    // ------------------------------------------------------------------
    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    // NOTE: pix_ce is a flop that mirrors (div_cnt == DIV_LAST) rather than a
    // decode of it. Reset can then force it low, which a pure decode could not
    // do for CLK_DIV=1, where the count is permanently at its last value.
    // NOTE: state is updated with <= so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pix_ce  <= (div_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    assign h_last = (hpos == H_LAST);
    assign v_last = (vpos == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                hpos <= '0;
                vpos <= v_last ? 11'd0 : vpos + 11'd1;
            end else begin
                hpos <= hpos + 11'd1;
            end
        end
    end

    assign active      = (hpos < H_VIS_W) && (vpos < V_VIS_W);
    assign frame_start = pix_ce && h_last && v_last;

    assign hsync_on = (hpos >= HS_START) && (hpos < HS_END);
    assign vsync_on = (vpos >= VS_START) && (vpos < VS_END);

`ifdef VGA_TESTPATTERN_EN
    // 8 column bands x 4 row bands; couleur is intentionally left unused.
    assign vis_colour = {hpos[7:5], vpos[6:5]};
`else
    assign vis_colour = couleur;
`endif

    // ------------------------------------------------------------------
    // Output stage: one pixel of latency, so the syncs and blanking line up
    // with the colour that was sampled for the same hpos/vpos.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_out <= '0;
            blank   <= 1'b1;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (pix_ce) begin
            pix_out <= active ? vis_colour : 5'd0;
            blank   <= ~active;
            hsync_n <= ~hsync_on;
            vsync_n <= ~vsync_on;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_gen
//   u_dut  : reduced raster (25 x 17, CLK_DIV=2). Scoreboard checking over
//            several frames, including a reset in the middle of a frame.
//   u_full : default 640x480 timing. Directed checks over the first line.
// ---------------------------------------------------------------------------
module tb_vga_scan_gen;

    localparam int DIV = 2;
    localparam int HV = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VV = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;   // 25
    localparam int VT = VV + VFP + VS + VBP;   // 17

    typedef struct packed {
        logic [4:0] pix;
        logic       blank;
        logic       hs_n;
        logic       vs_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reduced DUT ----------------
    logic        rst_s_n = 1'b0;
    logic [10:0] s_hpos, s_vpos;
    logic        s_active, s_hsync_n, s_vsync_n, s_blank, s_frame_start, s_pix_ce;
    logic [4:0]  s_couleur, s_pix_out;
    bit          flat_mode = 1'b0;

    function automatic logic [4:0] colour_of(input logic [10:0] h, input logic [10:0] v, input bit flat);
        return flat ? 5'h1F : (h[4:0] ^ {v[2:0], 2'b01});
    endfunction

    // Stand-in for the brick logic: combinational from the scan position.
    assign s_couleur = colour_of(s_hpos, s_vpos, flat_mode);

    vga_scan_gen #(
        .CLK_DIV(DIV), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) u_dut (
        .clk(clk), .reset_n(rst_s_n), .hpos(s_hpos), .vpos(s_vpos),
        .active(s_active), .couleur(s_couleur), .pix_out(s_pix_out),
        .hsync_n(s_hsync_n), .vsync_n(s_vsync_n), .blank(s_blank),
        .frame_start(s_frame_start), .pix_ce(s_pix_ce)
    );

    // ---------------- full-size DUT ----------------
    logic        rst_f_n = 1'b0;
    logic [10:0] f_hpos, f_vpos;
    logic        f_active, f_hsync_n, f_vsync_n, f_blank, f_frame_start, f_pix_ce;
    logic [4:0]  f_pix_out;

    vga_scan_gen u_full (
        .clk(clk), .reset_n(rst_f_n), .hpos(f_hpos), .vpos(f_vpos),
        .active(f_active), .couleur(5'h1F), .pix_out(f_pix_out),
        .hsync_n(f_hsync_n), .vsync_n(f_vsync_n), .blank(f_blank),
        .frame_start(f_frame_start), .pix_ce(f_pix_ce)
    );

    // ---------------- scoreboard: model / producer ----------------
    exp_t        sb_q[$];
    int          n_edges = 0;
    logic [10:0] mh = '0, mv = '0;
    int          mframes = 0;
    int          fs_seen = 0;

    initial begin
        bit   exp_ce;
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_frame_start === 1'b1) fs_seen++;
            if (!rst_s_n) begin
                n_edges = 0;
                mh = '0;
                mv = '0;
            end else begin
                exp_ce = (n_edges >= 1) && ((n_edges % DIV) == DIV - 1);
                check("pix_ce", s_pix_ce, exp_ce);
                check("frame_start", s_frame_start, exp_ce && mh == HT - 1 && mv == VT - 1);
                check("active", s_active, (mh < HV) && (mv < VV));
                if (exp_ce) begin
                    check("hpos", s_hpos, mh);
                    check("vpos", s_vpos, mv);
                    e.blank = !((mh < HV) && (mv < VV));
`ifdef VGA_TESTPATTERN_EN
                    e.pix   = e.blank ? 5'd0 : {mh[7:5], mv[6:5]};
`else
                    e.pix   = e.blank ? 5'd0 : colour_of(mh, mv, flat_mode);
`endif
                    e.hs_n  = !(mh >= HV + HFP && mh < HV + HFP + HS);
                    e.vs_n  = !(mv >= VV + VFP && mv < VV + VFP + VS);
                    sb_q.push_back(e);
                    if (mh == HT - 1) begin
                        mh = '0;
                        if (mv == VT - 1) begin
                            mv = '0;
                            mframes++;
                        end else begin
                            mv = mv + 11'd1;
                        end
                    end else begin
                        mh = mh + 11'd1;
                    end
                end
                n_edges++;
            end
        end
    end

    // ---------------- scoreboard: monitor ----------------
    initial begin
        bit   pending = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_s_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("pix_out", s_pix_out, e.pix);
                        check("blank", s_blank, e.blank);
                        check("hsync_n", s_hsync_n, e.hs_n);
                        check("vsync_n", s_vsync_n, e.vs_n);
                    end
                end
                pending = s_pix_ce;
            end
        end
    end

    task automatic check_small_reset(input string tag);
        check({tag, "_hpos"}, s_hpos, 0);
        check({tag, "_vpos"}, s_vpos, 0);
        check({tag, "_pix_out"}, s_pix_out, 0);
        check({tag, "_hsync_n"}, s_hsync_n, 1);
        check({tag, "_vsync_n"}, s_vsync_n, 1);
        check({tag, "_blank"}, s_blank, 1);
        check({tag, "_frame_start"}, s_frame_start, 0);
        check({tag, "_pix_ce"}, s_pix_ce, 0);
    endtask

    task automatic wait_model(input int frames, input int h, input int v, input string tag);
        bit hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            #1;
            hit = (mframes == frames) && (mh == h) && (mv == v);
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    // ---------------- full-size line checks ----------------
    task automatic full_line_check();
        int   ce_n = 0, hs_low = 0, vis = 0, bad_pix = 0, vs_low = 0;
        int   fall_h = -1;
        logic [10:0] last_h = '0;
        bit   prev_hs = 1'b1, wrapped = 1'b0;
        for (int c = 0; c < 3600 && ce_n < 810; c++) begin
            @(negedge clk);
            if (f_hsync_n == 1'b0 && prev_hs == 1'b1 && fall_h < 0) fall_h = int'(last_h);
            prev_hs = f_hsync_n;
            if (f_pix_ce) begin
                if (ce_n == 0) check("full_first_hpos", f_hpos, 0);
                if (ce_n == 1) check("full_second_hpos", f_hpos, 1);
                if (ce_n >= 1 && ce_n <= 800) begin
                    if (!f_hsync_n) hs_low++;
                    if (!f_vsync_n) vs_low++;
                    if (!f_blank) vis++;
`ifndef VGA_TESTPATTERN_EN
                    if (f_pix_out !== (f_blank ? 5'd0 : 5'h1F)) bad_pix++;
`endif
                end
                if (last_h == 11'd799 && f_hpos == 11'd0 && !wrapped) begin
                    wrapped = 1'b1;
                    check("full_wrap_vpos", f_vpos, 1);
                end
                last_h = f_hpos;
                ce_n++;
            end
        end
        check("full_ce_budget", ce_n, 810);
        check("full_wrapped", wrapped, 1);
        check("full_hsync_fall_hpos", fall_h, 656);
        check("full_hsync_low_count", hs_low, 96);
        check("full_vsync_low_count", vs_low, 0);
        check("full_visible_count", vis, 640);
        check("full_pix_vs_blank", bad_pix, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (20) @(negedge clk);
        check_small_reset("rst");
        check("full_rst_hsync_n", f_hsync_n, 1);
        check("full_rst_blank", f_blank, 1);
        check("full_rst_pix_ce", f_pix_ce, 0);

        @(posedge clk);
        #2;
        rst_s_n = 1'b1;
        rst_f_n = 1'b1;

        fork
            full_line_check();
            begin
                // Into the second frame, then reset mid-frame.
                wait_model(1, 10, 5, "run_a");
                @(posedge clk);
                #2;
                rst_s_n = 1'b0;
                #1;
                check_small_reset("async");
                sb_q.delete();
                repeat (3) @(negedge clk);
                check_small_reset("held");
                flat_mode = 1'b1;
                @(posedge clk);
                #2;
                rst_s_n = 1'b1;
                // One more full frame with constant colour, stop in vblank.
                wait_model(2, 3, 12, "run_b");
            end
        join

        check("sb_drain", sb_q.size() <= 1, 1);
        check("frame_start_pulses", fs_seen, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
